// File: rtl/axi_line_read_pkg.sv
// Shared types, AXI constants and line-geometry helpers for the line read master.
package axi_line_read_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, NEXT} state_e;

  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // Pixels are 32 bits, so a line is H_DISP*32 bits wide.
  function automatic int beats_per_line(input int h_disp, input int dw);
    return h_disp * 32 / dw;
  endfunction

  function automatic int bursts_per_line(input int h_disp, input int dw, input int bl);
    return beats_per_line(h_disp, dw) / bl;
  endfunction

  function automatic int burst_bytes(input int bl, input int dw);
    return bl * dw / 8;
  endfunction

  function automatic int line_stride(input int h_disp);
    return h_disp * 4;
  endfunction

  function automatic int arsize(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/axi_line_read_master_line_addr_counter.sv
// Frame-buffer line pointer: advances per finished line, wraps at V_DISP,
// and restarts at the frame base on frame_sync (deferred while a line is in flight).
module line_addr_counter
  import axi_line_read_pkg::*;
#(
  parameter int                  AW        = 32,
  parameter int                  H_DISP    = 1920,
  parameter int                  V_DISP    = 1080,
  parameter logic [AW-1:0]       BASE_ADDR = '0
) (
  input  logic          M_AXI_ACLK,
  input  logic          M_AXI_ARESET,
  input  logic          frame_sync,
  input  logic          busy,
  input  logic          line_done,
  output logic [AW-1:0] line_addr
);

  localparam int IW = (V_DISP > 1) ? $clog2(V_DISP) : 1;

  logic [IW-1:0] line_idx;
  logic          sync_pend;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      line_idx  <= '0;
      line_addr <= BASE_ADDR;
      sync_pend <= 1'b0;
    end else if (line_done) begin
      sync_pend <= 1'b0;
      // A sync arriving on the finishing cycle counts as pending.
      if (sync_pend || frame_sync || line_idx == IW'(V_DISP - 1)) begin
        line_idx  <= '0;
        line_addr <= BASE_ADDR;
      end else begin
        line_idx  <= line_idx + 1'b1;
        line_addr <= line_addr + AW'(line_stride(H_DISP));
      end
    end else if (frame_sync) begin
      if (busy) begin
        sync_pend <= 1'b1;
      end else begin
        line_idx  <= '0;
        line_addr <= BASE_ADDR;
      end
    end
  end

endmodule

// File: rtl/axi_line_read_master.sv
// AXI4 read master: fetches one display line as a run of fixed-length INCR bursts
// per request and streams every returned beat into the line FIFO.
module axi_line_read_master
  import axi_line_read_pkg::*;
#(
  parameter int                          AXI4_DATA_WIDTH = 128,
  parameter int                          AXI_ADDR_WIDTH  = 32,
  parameter int                          H_DISP          = 1920,
  parameter int                          V_DISP          = 1080,
  parameter int                          BURST_LEN       = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0]   FRAME_BASE_ADDR = '0
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          frame_sync,
  input  logic                          AXI_FULL_BURST_VALID,
  output logic                          AXI_FULL_BURST_READY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [AXI4_DATA_WIDTH-1:0]    M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic                          fifo_wr_en,
  output logic [AXI4_DATA_WIDTH-1:0]    fifo_wr_data,
  input  logic                          fifo_prog_full,
  output logic                          line_busy,
  output logic                          rd_error
);

  localparam int AW     = AXI_ADDR_WIDTH;
  localparam int BEATS  = beats_per_line(H_DISP, AXI4_DATA_WIDTH);
  localparam int BURSTS = bursts_per_line(H_DISP, AXI4_DATA_WIDTH, BURST_LEN);
  localparam int BBYTES = burst_bytes(BURST_LEN, AXI4_DATA_WIDTH);

  if ((BEATS % BURST_LEN) != 0 || BURST_LEN > 256) begin : g_bad_cfg
    $error("axi_line_read_master: BEATS_PER_LINE must be a multiple of BURST_LEN <= 256");
  end

  state_e        state_q, state_n;
  logic [AW-1:0] burst_addr, line_addr;
  logic [15:0]   burst_cnt;
  logic [7:0]    beat_cnt;
  logic          accept, beat_ok, last_beat, line_done;

  assign accept    = AXI_FULL_BURST_VALID & AXI_FULL_BURST_READY;
  assign beat_ok   = M_AXI_RVALID & M_AXI_RREADY;
  assign last_beat = (beat_cnt == 8'(BURST_LEN - 1));
  assign line_done = (state_q == NEXT) && (burst_cnt >= 16'(BURSTS - 1));

  assign M_AXI_ARADDR  = burst_addr;
  assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'(arsize(AXI4_DATA_WIDTH));
  assign M_AXI_ARBURST = ARBURST_INCR;
  assign M_AXI_ARVALID = (state_q == ADDR);
  assign M_AXI_RREADY  = (state_q == DATA) & ~fifo_prog_full;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state_q <= IDLE;
    else              state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (accept) state_n = ADDR;
      ADDR: if (M_AXI_ARREADY) state_n = DATA;
      DATA: if (beat_ok && last_beat) state_n = NEXT;
      NEXT: state_n = line_done ? IDLE : ADDR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      AXI_FULL_BURST_READY <= 1'b0;
      burst_addr           <= '0;
      burst_cnt            <= '0;
      beat_cnt             <= '0;
      line_busy            <= 1'b0;
      rd_error             <= 1'b0;
      fifo_wr_en           <= 1'b0;
      fifo_wr_data         <= '0;
    end else begin
      AXI_FULL_BURST_READY <= (state_n == IDLE);
      fifo_wr_en           <= beat_ok;
      if (beat_ok) fifo_wr_data <= M_AXI_RDATA;
      unique case (state_q)
        IDLE: if (accept) begin
          burst_addr <= line_addr;
          burst_cnt  <= '0;
          beat_cnt   <= '0;
          line_busy  <= 1'b1;
        end
        DATA: if (beat_ok) begin
          beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
          // RLAST must coincide exactly with the final counted beat.
          if (M_AXI_RRESP != RESP_OKAY || M_AXI_RLAST != last_beat) rd_error <= 1'b1;
        end
        NEXT: if (line_done) begin
          line_busy <= 1'b0;
        end else begin
          burst_addr <= burst_addr + AW'(BBYTES);
          burst_cnt  <= burst_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  line_addr_counter #(
    .AW        (AW),
    .H_DISP    (H_DISP),
    .V_DISP    (V_DISP),
    .BASE_ADDR (FRAME_BASE_ADDR)
  ) u_line_addr (
    .M_AXI_ACLK   (M_AXI_ACLK),
    .M_AXI_ARESET (M_AXI_ARESET),
    .frame_sync   (frame_sync),
    .busy         (line_busy | accept),
    .line_done    (line_done),
    .line_addr    (line_addr)
  );

endmodule

// File: tb/tb_axi_line_read_master.sv
// Directed bench for axi_line_read_master: a table of line fetches plus
// hand-written error and reset sequences, against a simple AXI slave/FIFO model.
module tb_axi_line_read_master;

  localparam int DW = 128, AW = 32, H = 1920, V = 8, BL = 16, NB = 30;

  logic          M_AXI_ACLK = 1'b0, M_AXI_ARESET = 1'b1, frame_sync = 1'b0;
  logic          AXI_FULL_BURST_VALID = 1'b0, AXI_FULL_BURST_READY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic [2:0]    M_AXI_ARSIZE;
  logic [1:0]    M_AXI_ARBURST;
  logic          M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
  logic [DW-1:0] M_AXI_RDATA = '0;
  logic [1:0]    M_AXI_RRESP = 2'b00;
  logic          M_AXI_RLAST = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_RREADY;
  logic          fifo_wr_en, fifo_prog_full = 1'b0, line_busy, rd_error;
  logic [DW-1:0] fifo_wr_data;

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  // V shortened so the frame wrap is reached quickly.
  axi_line_read_master #(
    .AXI4_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .H_DISP(H), .V_DISP(V),
    .BURST_LEN(BL), .FRAME_BASE_ADDR(32'h0000_0000)
  ) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET), .frame_sync(frame_sync),
    .AXI_FULL_BURST_VALID(AXI_FULL_BURST_VALID), .AXI_FULL_BURST_READY(AXI_FULL_BURST_READY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_prog_full(fifo_prog_full),
    .line_busy(line_busy), .rd_error(rd_error)
  );

  typedef struct {
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    logic          exp_err;
    int            fs_burst;
    int            stall_burst;
    int            err_burst;
    int            err_beat;
    int            err_kind;     // 1: bad RRESP, 2: early RLAST
    int            abort_burst;
  } vec_t;

  int            n_chk = 0, n_pass = 0, wr_cnt = 0, seq = 0;
  logic [DW-1:0] exp_q[$];
  vec_t          vecs[15];

  function automatic vec_t mk(input logic [AW-1:0] first, input logic [AW-1:0] last,
                              input logic err = 1'b0, input int fs = -1, input int stall = -1,
                              input int eb = -1, input int ebt = -1, input int ek = 0,
                              input int ab = -1);
    vec_t v;
    v.exp_first = first; v.exp_last = last; v.exp_err = err; v.fs_burst = fs;
    v.stall_burst = stall; v.err_burst = eb; v.err_beat = ebt; v.err_kind = ek;
    v.abort_burst = ab;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
  endtask

  task automatic die(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
    summary();
    $fatal(1, "bench stopped");
  endtask

  task automatic tick();
    @(negedge M_AXI_ACLK);
    #1;
  endtask

  always @(negedge M_AXI_ACLK) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("fifo_wr_unexpected", 1'b1, 1'b0);
      else                   check("fifo_wr_data", fifo_wr_data, exp_q.pop_front());
      wr_cnt++;
    end
  end

  task automatic do_line(input string nm, input vec_t v);
    int            t, k, sl, snap, start_wr;
    logic [AW-1:0] a0;
    logic [DW-1:0] d;
    seq++;
    t = 0;
    while (AXI_FULL_BURST_READY !== 1'b1) begin
      tick(); t++;
      if (t > 100) die({nm, " ready"});
    end
    AXI_FULL_BURST_VALID = 1'b1;
    tick();
    AXI_FULL_BURST_VALID = 1'b0;
    check({nm, " ready_drop"}, AXI_FULL_BURST_READY, 1'b0);
    check({nm, " busy_set"}, line_busy, 1'b1);
    start_wr = wr_cnt;
    for (int b = 0; b < NB; b++) begin
      t = 0;
      while (M_AXI_ARVALID !== 1'b1) begin
        tick(); t++;
        if (t > 50) die({nm, " arvalid"});
      end
      a0 = M_AXI_ARADDR;
      check({nm, " araddr"}, a0, v.exp_first + AW'(b * 256));
      if (b == 0) begin
        check({nm, " arlen"}, M_AXI_ARLEN, 8'd15);
        check({nm, " arsize"}, M_AXI_ARSIZE, 3'b100);
        check({nm, " arburst"}, M_AXI_ARBURST, 2'b01);
      end
      if (b == NB - 1) check({nm, " last_araddr"}, a0, v.exp_last);
      for (int i = 0; i < b % 3; i++) begin
        tick();
        check({nm, " araddr_hold"}, {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, a0});
      end
      M_AXI_ARREADY = 1'b1;
      k = 0; sl = 0; snap = 0;
      while (k < BL) begin
        tick();
        M_AXI_ARREADY = 1'b0;
        if (b == v.abort_burst && k == 5) begin
          M_AXI_ARESET = 1'b1; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
          tick();
          check({nm, " rst_arvalid"}, M_AXI_ARVALID, 1'b0);
          check({nm, " rst_rready"}, M_AXI_RREADY, 1'b0);
          check({nm, " rst_wr_en"}, fifo_wr_en, 1'b0);
          check({nm, " rst_ready"}, AXI_FULL_BURST_READY, 1'b0);
          check({nm, " rst_err"}, rd_error, 1'b0);
          M_AXI_ARESET = 1'b0;
          tick();
          check({nm, " ready_after_rst"}, AXI_FULL_BURST_READY, 1'b1);
          exp_q.delete();
          return;
        end
        d = {v.exp_first, 32'(b), 32'(k), 32'(seq)};
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = d;
        M_AXI_RRESP  = (v.err_kind == 1 && b == v.err_burst && k == v.err_beat) ? 2'b10 : 2'b00;
        M_AXI_RLAST  = (k == BL - 1) || (v.err_kind == 2 && b == v.err_burst && k == v.err_beat);
        frame_sync   = (b == v.fs_burst && k == 0);
        fifo_prog_full = (b == v.stall_burst && k == 4 && sl < 10);
        #1;
        if (fifo_prog_full) begin
          check({nm, " rready_stall"}, M_AXI_RREADY, 1'b0);
          if (sl == 0) snap = wr_cnt;
          else if (sl == 9) check({nm, " no_wr_stall"}, 32'(wr_cnt), 32'(snap));
          sl++;
        end else if (M_AXI_RREADY === 1'b1) begin
          exp_q.push_back(d);
          k++;
        end else begin
          die({nm, " rready"});
        end
      end
      tick();
      M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
      frame_sync = 1'b0; fifo_prog_full = 1'b0;
    end
    t = 0;
    while (AXI_FULL_BURST_READY !== 1'b1) begin
      tick(); t++;
      if (t > 20) die({nm, " ready_return"});
    end
    check({nm, " busy_clear"}, line_busy, 1'b0);
    check({nm, " wr_count"}, 32'(wr_cnt - start_wr), 32'd480);
    check({nm, " all_written"}, 32'(exp_q.size()), 32'd0);
    check({nm, " rd_error"}, rd_error, v.exp_err);
  endtask

  initial begin
    #1_500_000;
    die("watchdog");
  end

  initial begin
    vecs[0]  = mk(32'h0000, 32'h1D00);
    vecs[1]  = mk(32'h1E00, 32'h3B00);
    vecs[2]  = mk(32'h3C00, 32'h5900, 1'b0, -1, 7);
    vecs[3]  = mk(32'h5A00, 32'h7700);
    vecs[4]  = mk(32'h7800, 32'h9500);
    vecs[5]  = mk(32'h9600, 32'hB300);
    vecs[6]  = mk(32'hB400, 32'hD100);
    vecs[7]  = mk(32'hD200, 32'hEF00);
    vecs[8]  = mk(32'h0000, 32'h1D00);
    vecs[9]  = mk(32'h1E00, 32'h3B00);
    vecs[10] = mk(32'h3C00, 32'h5900);
    vecs[11] = mk(32'h5A00, 32'h7700);
    vecs[12] = mk(32'h7800, 32'h9500);
    vecs[13] = mk(32'h9600, 32'hB300, 1'b0, 10);
    vecs[14] = mk(32'h0000, 32'h1D00);

    tick(); tick();
    check("reset ready", AXI_FULL_BURST_READY, 1'b0);
    check("reset arvalid", M_AXI_ARVALID, 1'b0);
    check("reset rready", M_AXI_RREADY, 1'b0);
    check("reset wr_en", fifo_wr_en, 1'b0);
    check("reset busy", line_busy, 1'b0);
    check("reset rd_error", rd_error, 1'b0);
    check("reset araddr", M_AXI_ARADDR, 32'h0);
    M_AXI_ARESET = 1'b0;
    tick();
    check("ready after reset", AXI_FULL_BURST_READY, 1'b1);

    for (int i = 0; i < 15; i++) do_line($sformatf("line%0d", i), vecs[i]);

    // frame_sync while idle restarts the frame immediately
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    do_line("fs_idle", mk(32'h0000, 32'h1D00));

    do_line("err_resp", mk(32'h1E00, 32'h3B00, 1'b1, -1, -1, 3, 7, 1));
    do_line("err_sticky", mk(32'h3C00, 32'h5900, 1'b1));

    M_AXI_ARESET = 1'b1;
    tick();
    check("err clear ready", AXI_FULL_BURST_READY, 1'b0);
    check("err clear rd_error", rd_error, 1'b0);
    M_AXI_ARESET = 1'b0;
    tick();

    do_line("err_rlast", mk(32'h0000, 32'h1D00, 1'b1, -1, -1, 0, 14, 2));
    do_line("abort", mk(32'h1E00, 32'h3B00, 1'b0, -1, -1, -1, -1, 0, 12));
    do_line("post_abort", mk(32'h0000, 32'h1D00));

    summary();
    $finish;
  end

endmodule
